sort_step_sequencer: RTL and testbench
======================================

Name: sort_step_sequencer

Overview:
- Sequences an insertion sort over an N-element register array, one compare/swap per step.
- Each step is gated by step_en, so the VGA/7-seg visualisation can show every intermediate array state and the active indices.
- Sits between the user-input/tick logic (start button, step-rate divider) and the display renderer.
- Replaces the single-cycle combinational sort with a paced, observable sequencer.

Parameters:
- N, 8, number of elements (N >= 2)
- W, 4, bits per element (unsigned)
- IW, $clog2(N), index width (derived; not overridden)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin sort; sampled only in IDLE or DONE
- load_data  in  N*W  initial array; element k at bits [k*W +: W]
- step_en  in  1  perform one algorithm step in this cycle (RUN only); tie high for full speed
- data_out  out  N*W  current array contents, same packing as load_data
- cur_i  out  IW  outer-loop index
- cur_j  out  IW  compare position; the pair (cur_j-1, cur_j) is under test
- swapped  out  1  one-cycle pulse, coincident with data_out showing the swap
- busy  out  1  high in LOAD and RUN
- done  out  1  high in DONE; held until the next accepted start

Behaviour:
- Reset (async, rst_n=0): state=IDLE, data_out=0, cur_i=0, cur_j=0, swapped=0, busy=0, done=0. Takes effect immediately, including mid-sort. Deassertion is synchronised by the system reset bridge.
- States: IDLE, LOAD, RUN, DONE.
- IDLE / DONE, start=1: array <= load_data, cur_i <= 1, cur_j <= 1, done <= 0, go to LOAD.
- LOAD: one cycle, busy=1, step_en ignored, go to RUN. Timing: start at edge t, first step can be accepted at edge t+2.
- RUN, step_en=0: hold all state; swapped=0.
- RUN, step_en=1: compare a[cur_j-1] with a[cur_j] (unsigned).
  - If a[cur_j-1] > a[cur_j]: swap the pair and set swapped=1 on the next cycle. Then if cur_j==1 take ADVANCE, else cur_j <= cur_j-1.
  - Otherwise (less or equal): no swap, take ADVANCE. Equal values never swap, so the sort is stable.
- ADVANCE: if cur_i==N-1, go to DONE. Otherwise cur_i <= cur_i+1 and cur_j <= cur_i+1.
- DONE: busy=0, done=1. data_out holds the sorted array, ascending with index 0 smallest. cur_i/cur_j hold their last values.
- start while in LOAD/RUN: ignored, no restart.
- step_en outside RUN: ignored.
- Step count: minimum N-1 (pre-sorted input), maximum N(N-1)/2 (reverse-sorted input).
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: SORT_SWAP_COUNT_EN.
- Defined: adds output swap_count, width $clog2(N*(N-1)/2+1). Cleared on accepted start and on reset; incremented in the same edge as each swap; held in DONE.
- Undefined: swap_count port and counter are absent; all other behaviour is identical.

Decomposition:
- sort_pkg holds:
  - state enum sort_state_t {IDLE, LOAD, RUN, DONE}
  - element/index width helper function
  - the packing macro/function for the k-th element slice
- Sub-module compare_swap_unit: combinational. Takes the two W-bit operands and outputs gt, lo_out and hi_out. Instantiated once, driven through the cur_j-selected mux.

Test Plan:
- Reverse input, N=8, W=4: load 7,6,5,4,3,2,1,0 (index 0 first), step_en=1 -> done after 28 RUN steps; data_out = 0..7 ascending; 28 swapped pulses; swap_count=28 when enabled.
- Sorted input: load 0..7, step_en=1 -> done after exactly 7 steps; swapped never asserted; data_out unchanged.
- Single-step pacing: load 3,1,2,0,..., step_en pulsed every 5 cycles.
  - data_out and cur_i/cur_j change only on step_en cycles.
  - First step: cur_j=1, swap -> 1,3,2,0...
  - Next step: cur_i=2, cur_j=2.
- Duplicates: load 2,2,1,1,0,0,3,3 -> sorted 0,0,1,1,2,2,3,3; no swap on any equal compare (check swapped per step).
- Reset mid-sort: rst_n low after 10 steps -> same-cycle (async) data_out=0, busy=0, done=0, state IDLE. After release, a new start sorts correctly.
- start during RUN (pulse at step 5) -> ignored, sort completes with the original data. start in DONE -> reloads load_data, done drops, busy rises.

Source files
------------

// File: rtl/sort_pkg.sv
// Shared types and helpers for the paced insertion-sort sequencer.
// Optional swap counter is enabled with the SORT_SWAP_COUNT_EN macro.
package sort_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      RUN  = 2'd2,
      DONE = 2'd3
   } sort_state_t;

   // Index width for an n-element array; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Width able to hold the worst-case swap count n(n-1)/2.
   function automatic int swap_count_width(input int n);
      return $clog2(n * (n - 1) / 2 + 1);
   endfunction

   // LSB position of element k in a flat vector of w-bit elements.
   function automatic int elem_lsb(input int k, input int w);
      return k * w;
   endfunction

endpackage

// File: rtl/sort_step_sequencer_compare_swap_unit.sv
// Combinational compare/swap of one adjacent pair. a_lo sits at the lower
// array index; the outputs are the pair in ascending order. Equal operands
// pass through unchanged so the sort stays stable.
module compare_swap_unit #(
   parameter int W = 4
) (
   input  logic [W-1:0] a_lo,
   input  logic [W-1:0] a_hi,
   output logic         gt,
   output logic [W-1:0] lo_out,
   output logic [W-1:0] hi_out
);

   // Strict greater-than decides the swap; ties never swap.
   always_comb begin
      gt     = (a_lo > a_hi);
      lo_out = gt ? a_hi : a_lo;
      hi_out = gt ? a_lo : a_hi;
   end

endmodule

// File: rtl/sort_step_sequencer.sv
// Paced insertion sort over an N-element register array, one compare/swap
// per accepted step, so the display can render every intermediate state.
// Optional feature: define SORT_SWAP_COUNT_EN to add the swap_count output.
//
// Handshake: start is a request accepted only in IDLE or DONE (ignored in
// LOAD/RUN); step_en is a per-cycle request consumed only in RUN and ignored
// elsewhere. There is no back-pressure; all outputs are registered.
module sort_step_sequencer
   import sort_pkg::*;
#(
   parameter  int N  = 8,
   parameter  int W  = 4,
   localparam int IW = idx_width(N)
`ifdef SORT_SWAP_COUNT_EN
   ,
   localparam int SCW = swap_count_width(N)
`endif
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic [N*W-1:0]  load_data,
   input  logic            step_en,
   output logic [N*W-1:0]  data_out,
   output logic [IW-1:0]   cur_i,
   output logic [IW-1:0]   cur_j,
   output logic            swapped,
   output logic            busy,
   output logic            done,
`ifdef SORT_SWAP_COUNT_EN
   output logic [SCW-1:0]  swap_count,
`endif
   output sort_state_t     state_dbg
);

   sort_state_t           state, nxt_state;
   logic [N-1:0][W-1:0]   arr, nxt_arr;
   logic [IW-1:0]         nxt_i, nxt_j;
   logic                  nxt_swapped;
   logic                  advance;
   logic [IW-1:0]         j_lo;
   logic [W-1:0]          op_lo, op_hi, res_lo, res_hi;
   logic                  gt;
`ifdef SORT_SWAP_COUNT_EN
   logic [SCW-1:0]        nxt_cnt;
`endif

   assign data_out  = arr;
   assign state_dbg = state;

   // The pair under test is (cur_j-1, cur_j); cur_j >= 1 whenever it is used.
   assign j_lo  = cur_j - IW'(1);
   assign op_lo = arr[j_lo];
   assign op_hi = arr[cur_j];

   compare_swap_unit #(.W(W)) u_cmp (
      .a_lo   (op_lo),
      .a_hi   (op_hi),
      .gt     (gt),
      .lo_out (res_lo),
      .hi_out (res_hi)
   );

   // Next-state logic: load on accepted start, one compare/swap per RUN step.
   always_comb begin
      nxt_state   = state;
      nxt_arr     = arr;
      nxt_i       = cur_i;
      nxt_j       = cur_j;
      nxt_swapped = 1'b0;
      advance     = 1'b0;
`ifdef SORT_SWAP_COUNT_EN
      nxt_cnt     = swap_count;
`endif
      unique case (state)
         IDLE, DONE: begin
            if (start) begin
               for (int k = 0; k < N; k++) begin
                  nxt_arr[k] = load_data[elem_lsb(k, W) +: W];
               end
               nxt_i     = IW'(1);
               nxt_j     = IW'(1);
               nxt_state = LOAD;
`ifdef SORT_SWAP_COUNT_EN
               nxt_cnt   = '0;
`endif
            end
         end
         LOAD: begin
            nxt_state = RUN;
         end
         RUN: begin
            if (step_en) begin
               if (gt) begin
                  nxt_arr[j_lo]  = res_lo;
                  nxt_arr[cur_j] = res_hi;
                  nxt_swapped    = 1'b1;
`ifdef SORT_SWAP_COUNT_EN
                  nxt_cnt        = swap_count + SCW'(1);
`endif
                  if (cur_j == IW'(1)) advance = 1'b1;
                  else                 nxt_j   = j_lo;
               end else begin
                  advance = 1'b1;
               end
            end
         end
         default: begin
            nxt_state = IDLE;
         end
      endcase

      // The inserted element has settled: move to the next outer index.
      if (advance) begin
         if (cur_i == IW'(N - 1)) begin
            nxt_state = DONE;
         end else begin
            nxt_i = cur_i + IW'(1);
            nxt_j = cur_i + IW'(1);
         end
      end
   end

   // State, array and status registers; reset clears everything at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         arr        <= '0;
         cur_i      <= '0;
         cur_j      <= '0;
         swapped    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
`ifdef SORT_SWAP_COUNT_EN
         swap_count <= '0;
`endif
      end else begin
         state      <= nxt_state;
         arr        <= nxt_arr;
         cur_i      <= nxt_i;
         cur_j      <= nxt_j;
         swapped    <= nxt_swapped;
         busy       <= (nxt_state == LOAD) || (nxt_state == RUN);
         done       <= (nxt_state == DONE);
`ifdef SORT_SWAP_COUNT_EN
         swap_count <= nxt_cnt;
`endif
      end
   end

endmodule

// File: tb/tb_sort_step_sequencer.sv
// Randomized scoreboard bench for sort_step_sequencer. A nested-loop
// insertion-sort model pushes one expected snapshot per step; a negedge
// monitor pops a snapshot on every LOAD cycle and after every accepted step,
// and checks that nothing moves between steps.
module tb_sort_step_sequencer;
   import sort_pkg::*;

   localparam int N  = 8;
   localparam int W  = 4;
   localparam int IW = $clog2(N);
   localparam int EW = N * W + 2 * IW + 1;
`ifdef SORT_SWAP_COUNT_EN
   localparam int SCW = $clog2(N * (N - 1) / 2 + 1);
   logic [SCW-1:0] swap_count;
`endif

   logic            clk;
   logic            rst_n;
   logic            start;
   logic [N*W-1:0]  load_data;
   logic            step_en;
   logic [N*W-1:0]  data_out;
   logic [IW-1:0]   cur_i;
   logic [IW-1:0]   cur_j;
   logic            swapped;
   logic            busy;
   logic            done;
   sort_state_t     state_dbg;

   int checks = 0;
   int errors = 0;

   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] cur_ref;
   bit            have_ref = 0;
   bit            step_pending = 0;
   int            steps_seen = 0;
   int            swaps_seen = 0;

   sort_step_sequencer #(.N(N), .W(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .load_data  (load_data),
      .step_en    (step_en),
      .data_out   (data_out),
      .cur_i      (cur_i),
      .cur_j      (cur_j),
      .swapped    (swapped),
      .busy       (busy),
      .done       (done),
`ifdef SORT_SWAP_COUNT_EN
      .swap_count (swap_count),
`endif
      .state_dbg  (state_dbg)
   );

   // Clock and reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [EW-1:0] pack_rec(input int a[N], input int i, input int j, input bit sw);
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'(a[k]);
      return {v, IW'(i), IW'(j), sw};
   endfunction

   function automatic logic [N*W-1:0] to_vec(input int a[N]);
      logic [N*W-1:0] v;
      for (int k = 0; k < N; k++) v[k*W +: W] = W'(a[k]);
      return v;
   endfunction

   // Reference model: plain insertion sort, one snapshot per compare.
   task automatic model_push(input logic [N*W-1:0] vec, output int n_steps,
                             output int n_swaps, output logic [N*W-1:0] sorted_vec);
      int a[N];
      int orig[N];
      int j, tmp, idx;
      bit fin, sw;
      for (int k = 0; k < N; k++) begin
         a[k]    = int'(vec[k*W +: W]);
         orig[k] = a[k];
      end
      exp_q.push_back(pack_rec(a, 1, 1, 1'b0));
      n_steps = 0;
      n_swaps = 0;
      for (int i = 1; i < N; i++) begin
         j   = i;
         fin = 0;
         while (!fin) begin
            n_steps++;
            if (a[j-1] > a[j]) begin
               tmp = a[j-1]; a[j-1] = a[j]; a[j] = tmp;
               n_swaps++;
               sw = 1;
               if (j == 1) fin = 1;
               else        j--;
            end else begin
               sw  = 0;
               fin = 1;
            end
            if (!fin || i == N - 1) exp_q.push_back(pack_rec(a, i, j, sw));
            else                    exp_q.push_back(pack_rec(a, i + 1, i + 1, sw));
         end
      end
      // Independent final result: counting sort of the original values.
      idx = 0;
      sorted_vec = '0;
      for (int v = 0; v < (1 << W); v++) begin
         for (int k = 0; k < N; k++) begin
            if (orig[k] == v) begin
               sorted_vec[idx*W +: W] = W'(v);
               idx++;
            end
         end
      end
   endtask

   // Scoreboard monitor: pop on LOAD and after each accepted step, else check hold.
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_q.delete();
         have_ref     = 0;
         step_pending = 0;
      end else begin
         if (state_dbg == LOAD || step_pending) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow: got output with no expected entry at %0t", $time);
            end else begin
               cur_ref = exp_q.pop_front();
               if (state_dbg == LOAD) begin
                  check("load_snapshot", {data_out, cur_i, cur_j, swapped}, cur_ref);
                  steps_seen = 0;
                  swaps_seen = 0;
               end else begin
                  check("step_snapshot", {data_out, cur_i, cur_j, swapped}, cur_ref);
                  steps_seen++;
                  if (cur_ref[0]) swaps_seen++;
               end
               have_ref = 1;
            end
         end else if ((state_dbg == RUN || state_dbg == DONE) && have_ref) begin
            check("hold_snapshot", {data_out, cur_i, cur_j, swapped}, {cur_ref[EW-1:1], 1'b0});
         end
         step_pending = (state_dbg == RUN) && step_en;
      end
   end

   // Driver: one sort run. mode 0 = full speed, 1 = every 5th cycle, 2 = random.
   // Called and returns one time unit after a rising edge.
   task automatic run_sort(input logic [N*W-1:0] vec, input int mode,
                           input int start_at, input int reset_at);
      int n_steps, n_swaps, cyc;
      logic [N*W-1:0] sorted_vec;
      bit pulsed;
      load_data = vec;
      start     = 1'b1;
      model_push(vec, n_steps, n_swaps, sorted_vec);
      @(posedge clk); #1;
      start = 1'b0;
      check("start_state_load", state_dbg, LOAD);
      check("start_busy", busy, 1'b1);
      check("start_done_low", done, 1'b0);
`ifdef SORT_SWAP_COUNT_EN
      check("start_swap_count_clear", swap_count, 0);
`endif
      cyc    = 0;
      pulsed = 0;
      while (!done && cyc < 3000) begin
         case (mode)
            0:       step_en = 1'b1;
            1:       step_en = (cyc % 5 == 4);
            default: step_en = 1'($urandom_range(0, 1));
         endcase
         if (start_at >= 0 && !pulsed && steps_seen >= start_at && state_dbg == RUN) begin
            start     = 1'b1;
            load_data = ~vec;
            pulsed    = 1;
         end
         @(posedge clk); #1;
         start     = 1'b0;
         load_data = vec;
         cyc++;
         if (start_at >= 0 && pulsed && cyc < 3000 && !done && state_dbg != RUN && state_dbg != DONE) begin
            check("start_in_run_ignored", state_dbg, RUN);
         end
         if (reset_at >= 0 && steps_seen >= reset_at) begin
            #2 rst_n = 1'b0;
            #1;
            check("rst_data_out", data_out, 0);
            check("rst_busy", busy, 1'b0);
            check("rst_done", done, 1'b0);
            check("rst_state", state_dbg, IDLE);
            check("rst_idx", {cur_i, cur_j, swapped}, 0);
            step_en = 1'b0;
            @(negedge clk); @(negedge clk); #2;
            rst_n = 1'b1;
            @(posedge clk); #1;
            check("post_rst_idle", state_dbg, IDLE);
            return;
         end
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: done=%0b after %0d cycles, required 1", done, cyc);
      end
      step_en = 1'b0;
      @(negedge clk); #1;
      check("queue_drained", exp_q.size(), 0);
      check("step_count", steps_seen, n_steps);
      check("swap_pulses", swaps_seen, n_swaps);
      check("sorted_result", data_out, sorted_vec);
      check("done_flags", {done, busy}, 2'b10);
`ifdef SORT_SWAP_COUNT_EN
      check("swap_count_final", swap_count, n_swaps);
`endif
      @(posedge clk); #1;
   endtask

   // Stimulus sequence and final report.
   initial begin
      int t[N];
      rst_n     = 1'b0;
      start     = 1'b0;
      step_en   = 1'b0;
      load_data = '0;
      #12;
      check("reset_data_out", data_out, 0);
      check("reset_idx", {cur_i, cur_j}, 0);
      check("reset_flags", {swapped, busy, done}, 0);
      check("reset_state", state_dbg, IDLE);
      @(negedge clk); #2;
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Reverse input: worst case
      t = '{7, 6, 5, 4, 3, 2, 1, 0};
      run_sort(to_vec(t), 0, -1, -1);
      check("reverse_steps_28", steps_seen, 28);
      check("reverse_swaps_28", swaps_seen, 28);

      // Sorted input: best case, started from DONE
      t = '{0, 1, 2, 3, 4, 5, 6, 7};
      run_sort(to_vec(t), 0, -1, -1);
      check("sorted_steps_7", steps_seen, 7);
      check("sorted_swaps_0", swaps_seen, 0);

      // Single-step pacing
      t = '{3, 1, 2, 0, 4, 5, 6, 7};
      run_sort(to_vec(t), 1, -1, -1);

      // Duplicates stay stable
      t = '{2, 2, 1, 1, 0, 0, 3, 3};
      run_sort(to_vec(t), 0, -1, -1);

      // start pulsed during RUN is ignored
      t = '{7, 6, 5, 4, 3, 2, 1, 0};
      run_sort(to_vec(t), 0, 5, -1);

      // Reset mid-sort, then a fresh sort
      run_sort(to_vec(t), 0, -1, 10);
      t = '{5, 0, 7, 2, 2, 6, 1, 4};
      run_sort(to_vec(t), 0, -1, -1);

      // Random arrays with random pacing
      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < N; k++) t[k] = $urandom_range(0, (1 << W) - 1);
         run_sort(to_vec(t), (r % 2 == 0) ? 2 : 0, -1, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
